axi_stream_insert_header: RTL and testbench

- Inserts a 1–4 byte header in front of an AXI-Stream packet.
- Realigns every following payload byte so the output is one contiguous big-endian byte stream.
- Sits between a packet source and a downstream AXI-Stream sink.
- Accepts exactly one header per packet.

---
 rtl/axi_hdr_pkg.sv | 17 +
 rtl/byte_realign_buf.sv | 57 +++++
 rtl/axi_stream_insert_header.sv | 158 +++++++++++++++
 tb/tb_axi_stream_insert_header.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_hdr_pkg.sv
// Shared constants, FSM encoding and keep helper for the header-insertion datapath.
package axi_hdr_pkg;

    localparam int AXI_HDR_DATA_WD = 32;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] TAIL   = 2'd2;

    // Keep mask with the top 'cnt' lanes of an 'nb'-lane beat set; callers truncate to nb bits.
    function automatic logic [63:0] msb_keep(input int cnt, input int nb);
        return ((64'd1 << cnt) - 64'd1) << (nb - cnt);
    endfunction

endpackage

// File: rtl/byte_realign_buf.sv
// Two-beat byte FIFO: appends an MSB-aligned group of bytes behind the stored ones
// and can pop one full beat from the front in the same cycle.
module byte_realign_buf #(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = $clog2(2 * (DATA_WD / 8) + 1)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               i_append,
    input  logic [DATA_WD-1:0] i_app_data,
    input  logic [CNT_WD-1:0]  i_app_cnt,
    input  logic               i_pop,
    output logic [CNT_WD-1:0]  o_occ,
    output logic [CNT_WD-1:0]  o_comb_cnt,
    output logic [DATA_WD-1:0] o_head
);

    localparam int NB     = DATA_WD / 8;
    localparam int BUF_WD = 2 * DATA_WD;
    localparam logic [CNT_WD-1:0] NB_C = CNT_WD'(NB);

    logic [BUF_WD-1:0] r_buf;
    logic [CNT_WD-1:0] r_occ;
    logic [BUF_WD-1:0] w_app_mask;
    logic [BUF_WD-1:0] w_app_wide;
    logic [BUF_WD-1:0] w_comb;
    logic [CNT_WD-1:0] w_comb_cnt;

    // Lanes past the byte count are zeroed so unused buffer bytes always read as 0.
    generate
        for (genvar gi = 0; gi < 2 * NB; gi++) begin : g_mask
            assign w_app_mask[BUF_WD-1-8*gi -: 8] = (CNT_WD'(gi) < i_app_cnt) ? 8'hFF : 8'h00;
        end
    endgenerate

    assign w_app_wide = {i_app_data, {DATA_WD{1'b0}}} & w_app_mask;
    assign w_comb     = i_append ? (r_buf | (w_app_wide >> {r_occ, 3'b000})) : r_buf;
    assign w_comb_cnt = i_append ? (r_occ + i_app_cnt) : r_occ;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_buf <= '0;
            r_occ <= '0;
        end else if (i_pop) begin
            r_buf <= w_comb << DATA_WD;
            r_occ <= (w_comb_cnt > NB_C) ? (w_comb_cnt - NB_C) : '0;
        end else begin
            r_buf <= w_comb;
            r_occ <= w_comb_cnt;
        end
    end

    assign o_occ      = r_occ;
    assign o_comb_cnt = w_comb_cnt;
    assign o_head     = w_comb[BUF_WD-1 -: DATA_WD];

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends a 1..DATA_BYTE_WD byte header to an AXI-Stream packet and realigns the
// payload into one contiguous MSB-first byte stream behind a registered output stage.
module axi_stream_insert_header
    import axi_hdr_pkg::*;
#(
    parameter int DATA_WD      = AXI_HDR_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);

    localparam int CNT_WD = $clog2(2 * DATA_BYTE_WD + 1);
    localparam logic [CNT_WD-1:0] NB = CNT_WD'(DATA_BYTE_WD);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_valid_out;
    logic [DATA_WD-1:0]        r_data_out;
    logic [DATA_BYTE_WD-1:0]   r_keep_out;
    logic                      r_last_out;

    logic                      w_out_free;
    logic                      w_out_fire;
    logic                      w_in_fire;
    logic                      w_hdr_fire;
    logic                      w_emit;
    logic                      w_emit_last;
    logic [CNT_WD-1:0]         w_occ;
    logic [CNT_WD-1:0]         w_comb_cnt;
    logic [CNT_WD-1:0]         w_hdr_len;
    logic [CNT_WD-1:0]         w_keep_cnt;
    logic [CNT_WD+2:0]         w_hdr_shift;
    logic [DATA_WD-1:0]        w_hdr_aligned;
    logic [DATA_WD-1:0]        w_head;
    logic [DATA_BYTE_WD-1:0]   w_last_keep;
    logic [DATA_BYTE_WD-1:0]   w_beat_keep;
    logic                      w_append;
    logic [DATA_WD-1:0]        w_app_data;
    logic [CNT_WD-1:0]         w_app_cnt;
    logic                      w_unused_keep_insert;

    // byte_insert_cnt is authoritative; keep_insert carries no extra information.
    assign w_unused_keep_insert = ^keep_insert;

    assign w_out_free = !r_valid_out || ready_out;
    assign w_out_fire = r_valid_out && ready_out;

    // A full buffer still accepts the next beat, so a full beat is only launched once
    // it is known whether the packet ends there (an empty last beat must not add a beat).
    assign ready_in     = (r_state == STREAM) && w_out_free && (w_occ <= NB) && !rst_n;
    assign ready_insert = (r_state == IDLE) && !rst_n;
    assign w_in_fire    = valid_in && ready_in;
    assign w_hdr_fire   = valid_insert && ready_insert;

    assign w_hdr_len     = CNT_WD'(byte_insert_cnt) + CNT_WD'(1);
    assign w_hdr_shift   = {NB - w_hdr_len, 3'b000};
    assign w_hdr_aligned = data_insert << w_hdr_shift;
    assign w_keep_cnt    = CNT_WD'($countones(keep_in));

    assign w_append   = w_in_fire || w_hdr_fire;
    assign w_app_data = w_hdr_fire ? w_hdr_aligned : data_in;
    assign w_app_cnt  = w_hdr_fire ? w_hdr_len : w_keep_cnt;

    byte_realign_buf #(
        .DATA_WD (DATA_WD),
        .CNT_WD  (CNT_WD)
    ) u_buf (
        .clk        (clk),
        .srst       (rst_n),
        .i_append   (w_append),
        .i_app_data (w_app_data),
        .i_app_cnt  (w_app_cnt),
        .i_pop      (w_emit),
        .o_occ      (w_occ),
        .o_comb_cnt (w_comb_cnt),
        .o_head     (w_head)
    );

    assign w_last_keep = DATA_BYTE_WD'(msb_keep(int'(w_comb_cnt), DATA_BYTE_WD));
    assign w_beat_keep = w_emit_last ? w_last_keep : {DATA_BYTE_WD{1'b1}};

    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_emit_last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hdr_fire) w_next_state = STREAM;
            end
            STREAM: begin
                if (w_in_fire) begin
                    if (last_in) begin
                        w_emit       = 1'b1;
                        w_emit_last  = (w_comb_cnt <= NB);
                        w_next_state = TAIL;
                    end else if (w_comb_cnt >= NB) begin
                        w_emit = 1'b1;
                    end
                end
            end
            TAIL: begin
                // Either leftover bytes still need their closing beat, or we wait for it to drain.
                if (w_out_free) begin
                    if (w_occ != '0) begin
                        w_emit      = 1'b1;
                        w_emit_last = 1'b1;
                    end else if (w_out_fire && r_last_out) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_emit) begin
                r_valid_out <= 1'b1;
                r_data_out  <= w_head;
                r_keep_out  <= w_beat_keep;
                r_last_out  <= w_emit_last;
            end else if (w_out_fire) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign keep_out  = r_keep_out;
    assign last_out  = r_last_out;

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Randomised scoreboard bench: packets are modelled as byte queues and re-chunked into beats.
module tb_axi_stream_insert_header;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic [1:0]  byte_insert_cnt;
    logic        ready_insert;

    axi_stream_insert_header dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int          n_beats_seen = 0;
    logic [31:0] pkt_data[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int keep_bytes(input logic [3:0] k);
        int n = 0;
        for (int i = 0; i < 4; i++) if (k[i]) n++;
        return n;
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t e;
        e.data = d; e.keep = k; e.last = l;
        exp_q.push_back(e);
    endtask

    // Reference: flatten header + payload into bytes, then cut into 4-byte beats.
    task automatic model_push(input int h, input logic [31:0] hdr, input int nbeats, input logic [3:0] lkeep);
        logic [7:0] bq[$];
        int         k;
        int         n;
        beat_t      e;
        for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
        for (int b = 0; b < nbeats; b++) begin
            k = (b == nbeats - 1) ? keep_bytes(lkeep) : 4;
            for (int j = 0; j < k; j++) bq.push_back(pkt_data[b][31-8*j -: 8]);
        end
        while (bq.size() > 0) begin
            n = (bq.size() >= 4) ? 4 : bq.size();
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < n; j++) begin
                e.data[31-8*j -: 8] = bq.pop_front();
                e.keep[3-j] = 1'b1;
            end
            e.last = (bq.size() == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_header(input int h_cnt, input logic [31:0] hdr);
        int w = 0;
        valid_insert    = 1'b1;
        data_insert     = hdr;
        byte_insert_cnt = 2'(h_cnt);
        keep_insert     = 4'((1 << (h_cnt + 1)) - 1);
        @(negedge clk);
        while (!ready_insert && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("ready_insert_wait", ready_insert, 1);
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
        int w = 0;
        int n;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        @(negedge clk);
        while (!ready_in && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("ready_in_wait", ready_in, 1);
        chk("ready_insert_in_pkt", ready_insert, 0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        n = (gap > 0) ? $urandom_range(0, gap) : 0;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input int h_cnt, input logic [31:0] hdr, input int nbeats,
                               input logic [3:0] lkeep, input bit use_model, input bit early,
                               input int gap);
        if (use_model) model_push(h_cnt + 1, hdr, nbeats, lkeep);
        if (early) begin
            valid_in = 1'b1;
            data_in  = pkt_data[0];
            keep_in  = (nbeats == 1) ? lkeep : 4'hF;
            last_in  = (nbeats == 1);
            repeat (2) begin
                @(negedge clk);
                chk("ready_in_before_hdr", ready_in, 0);
            end
            @(posedge clk);
            #1;
        end
        send_header(h_cnt, hdr);
        for (int b = 0; b < nbeats; b++)
            send_beat(pkt_data[b], (b == nbeats - 1) ? lkeep : 4'hF, b == nbeats - 1, gap);
    endtask

    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: ready_out = 1'b1;
                1: ready_out = ($urandom_range(0, 3) != 0);
                default: ready_out = 1'b0;
            endcase
        end
    end

    // Monitor: compares every handshaken beat and checks output stability under backpressure.
    initial begin
        beat_t       e;
        logic        hold;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        hold = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", valid_out, 1);
                    chk("hold_data", data_out, pd);
                    chk("hold_keep", keep_out, pk);
                    chk("hold_last", last_out, pl);
                end
                if (valid_out && !ready_out) chk("ready_in_stall", ready_in, 0);
                if (valid_out && ready_out) begin
                    n_beats_seen++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_beat: got data=%h keep=%b last=%b, required no beat",
                                 data_out, keep_out, last_out);
                    end else begin
                        e = exp_q.pop_front();
                        $display("out beat %0d: data=%h keep=%b last=%b (exp %h %b %b)",
                                 n_beats_seen, data_out, keep_out, last_out, e.data, e.keep, e.last);
                        chk("beat_data", data_out, e.data);
                        chk("beat_keep", keep_out, e.keep);
                        chk("beat_last", last_out, e.last);
                    end
                end
                hold = valid_out && !ready_out;
                pd = data_out;
                pk = keep_out;
                pl = last_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] keep_tab[5];
        int         w;
        keep_tab[0] = 4'b0000; keep_tab[1] = 4'b1000; keep_tab[2] = 4'b1100;
        keep_tab[3] = 4'b1110; keep_tab[4] = 4'b1111;

        rst_n = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_ready_insert", ready_insert, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("idle_ready_insert", ready_insert, 1);
        @(posedge clk);
        #1;

        // Two-byte header, last beat keeps two bytes.
        pkt_data[0] = 32'h11223344;
        pkt_data[1] = 32'h5566BEEF;
        push_exp(32'hCCDD1122, 4'hF, 1'b0);
        push_exp(32'h33445566, 4'hF, 1'b1);
        send_packet(1, 32'hAABBCCDD, 2, 4'b1100, 1'b0, 1'b0, 0);

        // Four-byte header degenerates to pass-through; payload offered before the header.
        pkt_data[0] = 32'hA0A1A2A3;
        pkt_data[1] = 32'hB0B1B2B3;
        push_exp(32'h01020304, 4'hF, 1'b0);
        push_exp(32'hA0A1A2A3, 4'hF, 1'b0);
        push_exp(32'hB0B1B2B3, 4'hF, 1'b1);
        send_packet(3, 32'h01020304, 2, 4'hF, 1'b0, 1'b1, 0);

        // Three-byte header spills one byte into a tail beat; junk lanes must read 0.
        pkt_data[0] = 32'h10111213;
        pkt_data[1] = 32'h2021DEAD;
        push_exp(32'hA1B2C310, 4'hF, 1'b0);
        push_exp(32'h11121320, 4'hF, 1'b0);
        push_exp(32'h21000000, 4'b1000, 1'b1);
        send_packet(2, 32'h99A1B2C3, 2, 4'b1100, 1'b0, 1'b0, 0);

        // One-byte header, 16 beats, exact multiple of 4, with a 5-cycle downstream stall.
        for (int b = 0; b < 16; b++) pkt_data[b] = $urandom;
        fork
            send_packet(0, 32'h123456EE, 16, 4'b1110, 1'b1, 1'b0, 0);
            begin
                repeat (8) @(posedge clk);
                #1;
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join

        // Single empty last beat: only the header bytes come out.
        pkt_data[0] = $urandom;
        send_packet(1, 32'h0000F00D, 1, 4'b0000, 1'b1, 1'b0, 0);
        send_packet(3, 32'hCAFEBABE, 1, 4'b0000, 1'b1, 1'b0, 0);

        // Reset in the middle of a packet discards everything in flight.
        for (int b = 0; b < 6; b++) pkt_data[b] = $urandom;
        model_push(2, 32'h00003C5A, 6, 4'hF);
        send_header(1, 32'h00003C5A);
        send_beat(pkt_data[0], 4'hF, 1'b0, 0);
        send_beat(pkt_data[1], 4'hF, 1'b0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_ready_in", ready_in, 0);
        chk("midrst_ready_insert", ready_insert, 0);
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("postrst_ready_insert", ready_insert, 1);
        chk("postrst_valid_out", valid_out, 0);
        @(posedge clk);
        #1;
        pkt_data[0] = 32'h01234567;
        pkt_data[1] = 32'h89ABCDEF;
        send_packet(2, 32'h00ABCDEF, 2, 4'b1110, 1'b1, 1'b0, 0);

        // Randomised packets with random backpressure and source gaps.
        rdy_mode = 1;
        for (int p = 0; p < 30; p++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) pkt_data[b] = $urandom;
            send_packet($urandom_range(0, 3), $urandom, nb, keep_tab[$urandom_range(0, 4)],
                        1'b1, $urandom_range(0, 3) == 0, 2);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("final_valid_out", valid_out, 0);
        chk("final_ready_insert", ready_insert, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
